cla5_share_ctrl: RTL



---
 rtl/cla5_share_ctrl_pkg.sv | 14 +
 rtl/cla5_share_ctrl_if.sv | 42 ++++
 rtl/cla5_share_ctrl_cla_5bit.sv | 37 +++
 rtl/cla5_share_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cla5_share_ctrl_pkg.sv
// Shared types and constants for the two-requester CLA5 sequencer.
package cla5_pkg;

  localparam int CLA5_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/cla5_share_ctrl_if.sv
// Requester/response bus of cla5_share_ctrl; slave modport faces the controller.
interface cla5_share_ctrl_if import cla5_pkg::*; ();

  logic                  REQ0_VALID;
  logic                  REQ0_READY;
  logic [CLA5_WIDTH-1:0] REQ0_A;
  logic [CLA5_WIDTH-1:0] REQ0_B;
  logic                  REQ0_CIN;
  logic                  REQ0_SUB;

  logic                  REQ1_VALID;
  logic                  REQ1_READY;
  logic [CLA5_WIDTH-1:0] REQ1_A;
  logic [CLA5_WIDTH-1:0] REQ1_B;
  logic                  REQ1_CIN;
  logic                  REQ1_SUB;

  logic                  RSP_VALID;
  logic                  RSP_READY;
  req_id_t               RSP_ID;
  logic [CLA5_WIDTH-1:0] RSP_SUM;
  logic                  RSP_COUT;
  logic                  RSP_OVF;
  logic                  BUSY;

  modport master (
    output REQ0_VALID, REQ0_A, REQ0_B, REQ0_CIN, REQ0_SUB,
    output REQ1_VALID, REQ1_A, REQ1_B, REQ1_CIN, REQ1_SUB,
    output RSP_READY,
    input  REQ0_READY, REQ1_READY,
    input  RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT, RSP_OVF, BUSY
  );

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_CIN, REQ0_SUB,
    input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_CIN, REQ1_SUB,
    input  RSP_READY,
    output REQ0_READY, REQ1_READY,
    output RSP_VALID, RSP_ID, RSP_SUM, RSP_COUT, RSP_OVF, BUSY
  );

endinterface

// File: rtl/cla5_share_ctrl_cla_5bit.sv
// Combinational 5-bit carry-lookahead adder shared by both requesters.
module cla_5bit import cla5_pkg::*; (
  input  logic [CLA5_WIDTH-1:0] a,
  input  logic [CLA5_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [CLA5_WIDTH-1:0] sum,
  output logic                  cout
);

  logic [CLA5_WIDTH-1:0] g, p;
  logic [CLA5_WIDTH:0]   c;
  logic                  acc, pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat OR of generate terms gated by the propagate chain above them.
  always_comb begin
    c   = '0;
    acc = 1'b0;
    pp  = 1'b1;
    c[0] = cin;
    for (int i = 0; i < CLA5_WIDTH; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
  end

  assign sum  = p ^ c[CLA5_WIDTH-1:0];
  assign cout = c[CLA5_WIDTH];

endmodule

// File: rtl/cla5_share_ctrl.sv
// Round-robin sequencer sharing one cla_5bit between two requesters.
// Define CLA5_SHARE_SUB_EN to honour the SUB inputs (B inversion, forced carry-in).
module cla5_share_ctrl import cla5_pkg::*; #(
  parameter int WIDTH   = CLA5_WIDTH,
  parameter bit RR_INIT = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  cla5_share_ctrl_if.slave   bus
);

  state_t             state_q, state_d;
  req_id_t            ptr_q, ptr_d;
  req_id_t            grant;
  logic               accept;

  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               op_cin_q, op_cin_d;
  req_id_t            op_id_q, op_id_d;
`ifdef CLA5_SHARE_SUB_EN
  logic               op_sub_q, op_sub_d;
`endif

  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  req_id_t            rsp_id_q, rsp_id_d;

  logic [WIDTH-1:0]   add_b, add_sum;
  logic               add_cin, add_cout;

  // Contested cycles go to the pointer; a lone requester always wins.
  always_comb begin
    grant = ptr_q;
    if (bus.REQ0_VALID && !bus.REQ1_VALID)      grant = 1'b0;
    else if (bus.REQ1_VALID && !bus.REQ0_VALID) grant = 1'b1;
  end

  assign bus.REQ0_READY = (state_q == IDLE) && !RST && (grant == 1'b0);
  assign bus.REQ1_READY = (state_q == IDLE) && !RST && (grant == 1'b1);
  assign accept = grant ? (bus.REQ1_VALID && bus.REQ1_READY)
                        : (bus.REQ0_VALID && bus.REQ0_READY);

`ifdef CLA5_SHARE_SUB_EN
  assign add_b   = op_sub_q ? ~op_b_q : op_b_q;
  assign add_cin = op_sub_q | op_cin_q;
`else
  assign add_b   = op_b_q;
  assign add_cin = op_cin_q;
`endif

  cla_5bit u_cla (
    .a    (op_a_q),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_cin_d   = op_cin_q;
    op_id_d    = op_id_q;
`ifdef CLA5_SHARE_SUB_EN
    op_sub_d   = op_sub_q;
`endif
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      IDLE: if (accept) begin
        op_a_d   = grant ? bus.REQ1_A   : bus.REQ0_A;
        op_b_d   = grant ? bus.REQ1_B   : bus.REQ0_B;
        op_cin_d = grant ? bus.REQ1_CIN : bus.REQ0_CIN;
`ifdef CLA5_SHARE_SUB_EN
        op_sub_d = grant ? bus.REQ1_SUB : bus.REQ0_SUB;
`endif
        op_id_d  = grant;
        ptr_d    = ~grant;
        state_d  = EXEC;
      end
      EXEC: begin
        rsp_sum_d  = add_sum;
        rsp_cout_d = add_cout;
        rsp_ovf_d  = (op_a_q[WIDTH-1] == add_b[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != op_a_q[WIDTH-1]);
        rsp_id_d   = op_id_q;
        state_d    = RESP;
      end
      RESP: if (bus.RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ptr_q      <= RR_INIT;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cin_q   <= 1'b0;
      op_id_q    <= 1'b0;
`ifdef CLA5_SHARE_SUB_EN
      op_sub_q   <= 1'b0;
`endif
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_cin_q   <= op_cin_d;
      op_id_q    <= op_id_d;
`ifdef CLA5_SHARE_SUB_EN
      op_sub_q   <= op_sub_d;
`endif
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign bus.RSP_VALID = (state_q == RESP);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.RSP_ID    = rsp_id_q;
  assign bus.RSP_SUM   = rsp_sum_q;
  assign bus.RSP_COUT  = rsp_cout_q;
  assign bus.RSP_OVF   = rsp_ovf_q;

endmodule
